// File: rtl/hazard_unit_mc.sv
// hazard_unit_mc
// Hazard control for the 5-stage MIPS pipeline: multi-cycle load-use stalls,
// taken-branch flushes resolved in a configurable stage, and a whole-pipeline
// freeze while memory is busy. Keeps saturating stall/flush event counters.
//
// Parameters
//   REG_W    register-specifier width
//   LOAD_LAT bubbles between a load in EX and a dependent instruction in ID (1..7)
//   BR_STAGE stage resolving taken branches (1=ID, 2=EX, 3=MEM)
//   CNT_W    performance-counter width
//
// Ports
//   clk_i, rst_i                  clock (rising edge), async active-low reset
//   id_ex_memread_i, id_ex_rt_i   load in EX and its destination register
//   if_id_rs_i, if_id_rt_i        ID-stage source registers
//   if_id_uses_rt_i               ID instruction really reads rt
//   branch_taken_i                taken branch/jump in stage BR_STAGE
//   mem_busy_i                    memory not ready, hold everything
//   cnt_clr_i                     synchronous clear of both counters
//   pc_write_o, if_id_write_o     PC and IF/ID write enables
//   if_flush_o, id_flush_o, ex_flush_o  per-stage control flushes
//   freeze_o                      hold every pipeline register
//   stall_cycles_o                load-use bubble cycles inserted
//   flush_events_o                taken-branch flush events
module hazard_unit_mc #(
  parameter int REG_W    = 5,
  parameter int LOAD_LAT = 1,
  parameter int BR_STAGE = 3,
  parameter int CNT_W    = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             id_ex_memread_i,
  input  logic [REG_W-1:0] id_ex_rt_i,
  input  logic [REG_W-1:0] if_id_rs_i,
  input  logic [REG_W-1:0] if_id_rt_i,
  input  logic             if_id_uses_rt_i,
  input  logic             branch_taken_i,
  input  logic             mem_busy_i,
  input  logic             cnt_clr_i,
  output logic             pc_write_o,
  output logic             if_id_write_o,
  output logic             if_flush_o,
  output logic             id_flush_o,
  output logic             ex_flush_o,
  output logic             freeze_o,
  output logic [CNT_W-1:0] stall_cycles_o,
  output logic [CNT_W-1:0] flush_events_o
);

  typedef enum logic {IDLE, LSTALL} state_e;

  localparam logic [2:0] LatMinusOne = 3'(LOAD_LAT - 1);
  localparam logic       MultiCycle  = (LOAD_LAT > 1);
  localparam logic       BrFlushId   = (BR_STAGE >= 2);
  localparam logic       BrFlushEx   = (BR_STAGE == 3);

  state_e           state_q, state_d;
  logic [2:0]       rem_q, rem_d;
  logic [CNT_W-1:0] stallCnt_q, stallCnt_d;
  logic [CNT_W-1:0] flushCnt_q, flushCnt_d;

  logic hazard;
  logic stall;
  logic flushEvt;

  // Load-use detection. Register 0 is never a real dependency.
  assign hazard = id_ex_memread_i && (id_ex_rt_i != '0) &&
                  ((id_ex_rt_i == if_id_rs_i) ||
                   (if_id_uses_rt_i && (id_ex_rt_i == if_id_rt_i)));

  // Busy masks everything; a taken branch makes the stalled ID instruction
  // wrong-path, so it also suppresses any stall (pending or new).
  assign flushEvt = !mem_busy_i && branch_taken_i;
  assign stall    = !mem_busy_i && !branch_taken_i &&
                    ((state_q == LSTALL) || hazard);

  assign freeze_o      = mem_busy_i;
  assign pc_write_o    = !mem_busy_i && !stall;
  assign if_id_write_o = !mem_busy_i && !stall;
  assign if_flush_o    = flushEvt;
  assign id_flush_o    = stall || (flushEvt && BrFlushId);
  assign ex_flush_o    = flushEvt && BrFlushEx;

  // rem counts the stall cycles still owed after the current one; busy
  // cycles leave it untouched so they stretch but never shorten the stall.
  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    if (!mem_busy_i) begin
      if (branch_taken_i) begin
        state_d = IDLE;
        rem_d   = 3'd0;
      end else if (state_q == LSTALL) begin
        if (rem_q == 3'd1) begin
          state_d = IDLE;
          rem_d   = 3'd0;
        end else begin
          rem_d = rem_q - 3'd1;
        end
      end else if (hazard && MultiCycle) begin
        state_d = LSTALL;
        rem_d   = LatMinusOne;
      end
    end
  end

  // Saturating counters; clear has priority over increment.
  always_comb begin
    stallCnt_d = stallCnt_q;
    flushCnt_d = flushCnt_q;
    if (cnt_clr_i) begin
      stallCnt_d = '0;
      flushCnt_d = '0;
    end else begin
      if (stall && (stallCnt_q != '1)) stallCnt_d = stallCnt_q + CNT_W'(1);
      if (flushEvt && (flushCnt_q != '1)) flushCnt_d = flushCnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q    <= IDLE;
      rem_q      <= 3'd0;
      stallCnt_q <= '0;
      flushCnt_q <= '0;
    end else begin
      state_q    <= state_d;
      rem_q      <= rem_d;
      stallCnt_q <= stallCnt_d;
      flushCnt_q <= flushCnt_d;
    end
  end

  assign stall_cycles_o = stallCnt_q;
  assign flush_events_o = flushCnt_q;

endmodule

// File: tb/tb_hazard_unit_mc.sv
// Testbench for hazard_unit_mc. Two instances share the same stimulus:
//   A: LOAD_LAT=3, BR_STAGE=3, CNT_W=4
//   B: LOAD_LAT=1, BR_STAGE=1, CNT_W=16
// A reference model tracks "stall cycles still owed" per instance; expected
// outputs are queued by the driver and popped by a monitor on the falling edge.
module tb_hazard_unit_mc;

  typedef struct {
    logic [5:0]  ctrl;   // {pc_write, if_id_write, if_flush, id_flush, ex_flush, freeze}
    logic [15:0] stall;
    logic [15:0] flush;
  } exp_t;

  logic       clk_i = 1'b0;
  logic       rst_i = 1'b0;
  logic       memRead = 1'b0;
  logic [4:0] exRt = '0, idRs = '0, idRt = '0;
  logic       usesRt = 1'b0, brTaken = 1'b0, memBusy = 1'b0, cntClr = 1'b0;

  logic        pcwA, ifidwA, iffA, idfA, exfA, frzA;
  logic [3:0]  stallA, flushA;
  logic        pcwB, ifidwB, iffB, idfB, exfB, frzB;
  logic [15:0] stallB, flushB;

  exp_t qA[$];
  exp_t qB[$];

  int total = 0;
  int bad   = 0;

  int modelLat[2] = '{3, 1};
  int modelBr[2]  = '{3, 1};
  int modelMax[2] = '{15, 65535};
  int owed[2]     = '{0, 0};
  int sCnt[2]     = '{0, 0};
  int fCnt[2]     = '{0, 0};

  always #5 clk_i = ~clk_i;

  hazard_unit_mc #(.REG_W(5), .LOAD_LAT(3), .BR_STAGE(3), .CNT_W(4)) dutA (
    .clk_i(clk_i), .rst_i(rst_i),
    .id_ex_memread_i(memRead), .id_ex_rt_i(exRt),
    .if_id_rs_i(idRs), .if_id_rt_i(idRt), .if_id_uses_rt_i(usesRt),
    .branch_taken_i(brTaken), .mem_busy_i(memBusy), .cnt_clr_i(cntClr),
    .pc_write_o(pcwA), .if_id_write_o(ifidwA),
    .if_flush_o(iffA), .id_flush_o(idfA), .ex_flush_o(exfA),
    .freeze_o(frzA), .stall_cycles_o(stallA), .flush_events_o(flushA)
  );

  hazard_unit_mc #(.REG_W(5), .LOAD_LAT(1), .BR_STAGE(1), .CNT_W(16)) dutB (
    .clk_i(clk_i), .rst_i(rst_i),
    .id_ex_memread_i(memRead), .id_ex_rt_i(exRt),
    .if_id_rs_i(idRs), .if_id_rt_i(idRt), .if_id_uses_rt_i(usesRt),
    .branch_taken_i(brTaken), .mem_busy_i(memBusy), .cnt_clr_i(cntClr),
    .pc_write_o(pcwB), .if_id_write_o(ifidwB),
    .if_flush_o(iffB), .id_flush_o(idfB), .ex_flush_o(exfB),
    .freeze_o(frzB), .stall_cycles_o(stallB), .flush_events_o(flushB)
  );

  // Reference model: compute this cycle's expected outputs for instance k,
  // then advance the model to what the next cycle should see.
  function automatic exp_t modelStep(input int k, input logic hz);
    exp_t e;
    logic doStall = 1'b0;
    logic doFlush = 1'b0;
    e.ctrl  = 6'b110000;
    e.stall = 16'(sCnt[k]);
    e.flush = 16'(fCnt[k]);
    if (memBusy) begin
      e.ctrl = 6'b000001;
    end else if (brTaken) begin
      doFlush = 1'b1;
      e.ctrl  = {2'b11, 1'b1, (modelBr[k] >= 2), (modelBr[k] == 3), 1'b0};
      owed[k] = 0;
    end else if (owed[k] > 0) begin
      doStall = 1'b1;
      owed[k] = owed[k] - 1;
    end else if (hz) begin
      doStall = 1'b1;
      owed[k] = modelLat[k] - 1;
    end
    if (doStall) e.ctrl = 6'b000100;
    if (cntClr) begin
      sCnt[k] = 0;
      fCnt[k] = 0;
    end else begin
      if (doStall && sCnt[k] < modelMax[k]) sCnt[k] = sCnt[k] + 1;
      if (doFlush && fCnt[k] < modelMax[k]) fCnt[k] = fCnt[k] + 1;
    end
    return e;
  endfunction

  task automatic applyStimulus(input logic mr, input logic [4:0] rt, input logic [4:0] rs,
                               input logic [4:0] srt, input logic ur, input logic br,
                               input logic busy, input logic clr);
    logic hz;
    @(posedge clk_i);
    #1;
    rst_i   = 1'b1;
    memRead = mr;  exRt = rt;  idRs = rs;  idRt = srt;  usesRt = ur;
    brTaken = br;  memBusy = busy;  cntClr = clr;
    hz = mr && (rt != 5'd0) && ((rt == rs) || (ur && (rt == srt)));
    qA.push_back(modelStep(0, hz));
    qB.push_back(modelStep(1, hz));
  endtask

  // Assert reset asynchronously in the middle of a cycle, inputs quiet.
  task automatic doReset();
    exp_t e;
    @(posedge clk_i);
    #1;
    rst_i   = 1'b0;
    memRead = 1'b0;  exRt = '0;  idRs = '0;  idRt = '0;  usesRt = 1'b0;
    brTaken = 1'b0;  memBusy = 1'b0;  cntClr = 1'b0;
    for (int k = 0; k < 2; k++) begin
      owed[k] = 0;
      sCnt[k] = 0;
      fCnt[k] = 0;
    end
    e.ctrl  = 6'b110000;
    e.stall = 16'd0;
    e.flush = 16'd0;
    qA.push_back(e);
    qB.push_back(e);
  endtask

  task automatic checkOutput(input string name, input exp_t e, input logic [5:0] ctrl,
                             input logic [15:0] st, input logic [15:0] fl);
    total++;
    if (ctrl !== e.ctrl) begin
      bad++;
      $display("[TB] FAIL %s ctrl got=%b want=%b at %0t", name, ctrl, e.ctrl, $time);
    end
    total++;
    if (st !== e.stall) begin
      bad++;
      $display("[TB] FAIL %s stall_cycles got=%0d want=%0d at %0t", name, st, e.stall, $time);
    end
    total++;
    if (fl !== e.flush) begin
      bad++;
      $display("[TB] FAIL %s flush_events got=%0d want=%0d at %0t", name, fl, e.flush, $time);
    end
  endtask

  // Monitor: outputs are valid every cycle, so pop one entry per falling edge.
  always @(negedge clk_i) begin
    exp_t e;
    if (qA.size() > 0) begin
      e = qA.pop_front();
      checkOutput("A", e, {pcwA, ifidwA, iffA, idfA, exfA, frzA}, {12'd0, stallA}, {12'd0, flushA});
    end
    if (qB.size() > 0) begin
      e = qB.pop_front();
      checkOutput("B", e, {pcwB, ifidwB, iffB, idfB, exfB, frzB}, stallB, flushB);
    end
  end

  initial begin
    doReset();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);

    // lw $2 in EX, add $3,$2,$4 in ID; load leaves EX after one cycle
    applyStimulus(1, 2, 2, 4, 1, 0, 0, 0);
    repeat (4) applyStimulus(0, 0, 2, 4, 1, 0, 0, 0);

    // false hazards
    applyStimulus(1, 0, 0, 5, 1, 0, 0, 0);
    applyStimulus(1, 2, 3, 2, 0, 0, 0, 0);
    // rt dependency that is real
    applyStimulus(1, 6, 1, 6, 1, 0, 0, 0);
    repeat (3) applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);

    // taken branch
    applyStimulus(0, 0, 0, 0, 0, 1, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);

    // busy for two cycles in the middle of a stall
    applyStimulus(1, 7, 7, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    repeat (2) applyStimulus(0, 0, 0, 0, 0, 0, 1, 0);
    repeat (3) applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);

    // branch cancels a pending stall
    applyStimulus(1, 3, 3, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 1, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);

    // continuous hazard: saturate the 4-bit counter
    repeat (22) applyStimulus(1, 4, 4, 0, 0, 0, 0, 0);
    // clear together with a stall
    applyStimulus(1, 4, 4, 0, 0, 0, 0, 1);
    repeat (2) applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);

    // reset in the middle of a stall
    applyStimulus(1, 5, 5, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    doReset();
    repeat (2) applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);

    // randomized phase with small register indices to provoke hazards
    for (int i = 0; i < 600; i++) begin
      applyStimulus(1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)),
                    5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                    1'($urandom_range(0, 1)), ($urandom_range(0, 9) == 0),
                    ($urandom_range(0, 6) == 0), ($urandom_range(0, 40) == 0));
    end

    @(posedge clk_i);
    @(negedge clk_i);
    #1;
    total++;
    if (qA.size() != 0 || qB.size() != 0) begin
      bad++;
      $display("[TB] FAIL drain leftA=%0d leftB=%0d want=0", qA.size(), qB.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
